ebpc_decoder: RTL and testbench

Streaming decoder for the EBPC activation codec. It rebuilds a block of `num_words_i` data words from two compressed byte streams and emits them on a ready/valid output with a per-block last flag.
- The ZNZ stream carries the zero/non-zero mask, zero-run-length encoded.
- The BPC stream carries the non-zero values, one per beat; this revision has no bit-plane transform.

It sits between the compressed-stream DMA/FIFOs and the accelerator input.

---
 rtl/ebpc_decoder.sv | 186 ++++++++++++++++++
 tb/tb_ebpc_decoder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebpc_decoder.sv
// EBPC activation decoder: rebuilds num_words_i words from the ZNZ mask stream and BPC value stream.
// Build option: EBPC_DEC_ZRLE_EN selects the zero-run-length ZNZ format; without it ZNZ is a plain bitmask.
module ebpc_decoder #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned LOG_MAX_WORDS = 24,
    parameter int unsigned ZRL_W         = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [LOG_MAX_WORDS-1:0] num_words_i,
    input  logic                     num_words_vld_i,
    output logic                     num_words_rdy_o,
    input  logic [DATA_W-1:0]        bpc_i,
    input  logic                     bpc_vld_i,
    output logic                     bpc_rdy_o,
    input  logic [DATA_W-1:0]        znz_i,
    input  logic                     znz_vld_i,
    output logic                     znz_rdy_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     last_o,
    output logic                     vld_o,
    input  logic                     rdy_i
);

    localparam int unsigned CW = $clog2(2 * DATA_W + 1);
    localparam logic [CW-1:0] BYTE_BITS = CW'(DATA_W);
`ifdef EBPC_DEC_ZRLE_EN
    localparam logic [CW-1:0] ZSYM_BITS = CW'(ZRL_W + 1);

    typedef enum logic [1:0] {IDLE, DECODE, ZRUN} state_e;
`else
    typedef enum logic [0:0] {IDLE, DECODE} state_e;
`endif

    state_e state_q, state_d;
    logic                     init_q;
    logic [DATA_W-1:0]        buf_q, buf_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [LOG_MAX_WORDS-1:0] rem_q, rem_d;
`ifdef EBPC_DEC_ZRLE_EN
    logic [ZRL_W-1:0]         run_q, run_d;
`endif
    logic [DATA_W-1:0]        data_q;
    logic                     last_q, vld_q;

    logic                     out_can, emit, emit_last, take;
    logic [DATA_W-1:0]        emit_data;
    logic [2*DATA_W-1:0]      win;
    logic [CW-1:0]            avail, used;

    assign out_can   = !vld_q || rdy_i;
    assign emit_last = (rem_q == LOG_MAX_WORDS'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // The bit window is the buffered bits, left-aligned, with a freshly taken
    // ZNZ byte appended directly behind them, so a symbol straddling a byte
    // boundary still decodes in a single cycle.
    always_comb begin
        state_d         = state_q;
        buf_d           = buf_q;
        cnt_d           = cnt_q;
        rem_d           = rem_q;
`ifdef EBPC_DEC_ZRLE_EN
        run_d           = run_q;
`endif
        num_words_rdy_o = 1'b0;
        znz_rdy_o       = 1'b0;
        bpc_rdy_o       = 1'b0;
        take            = 1'b0;
        used            = '0;
        emit            = 1'b0;
        emit_data       = '0;
        win             = {buf_q, {DATA_W{1'b0}}};
        avail           = cnt_q;

        case (state_q)
            IDLE: begin
                num_words_rdy_o = init_q;
                if (init_q && num_words_vld_i && (num_words_i != '0)) begin
                    rem_d   = num_words_i;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (out_can) begin
`ifdef EBPC_DEC_ZRLE_EN
                    znz_rdy_o = (cnt_q == '0) || (!buf_q[DATA_W-1] && (cnt_q < ZSYM_BITS));
`else
                    znz_rdy_o = (cnt_q == '0);
`endif
                    take = znz_rdy_o && znz_vld_i;
                    if (take) begin
                        win   = win | ({znz_i, {DATA_W{1'b0}}} >> cnt_q);
                        avail = cnt_q + BYTE_BITS;
                    end
                    if (avail != '0) begin
                        if (win[2*DATA_W-1]) begin
                            bpc_rdy_o = 1'b1;
                            if (bpc_vld_i) begin
                                emit      = 1'b1;
                                emit_data = bpc_i;
                                used      = CW'(1);
                            end
                        end
`ifdef EBPC_DEC_ZRLE_EN
                        else if (avail >= ZSYM_BITS) begin
                            emit = 1'b1;
                            used = ZSYM_BITS;
                            if (!emit_last && (win[2*DATA_W-2 -: ZRL_W] != '0)) begin
                                run_d   = win[2*DATA_W-2 -: ZRL_W];
                                state_d = ZRUN;
                            end
                        end
`else
                        else begin
                            emit = 1'b1;
                            used = CW'(1);
                        end
`endif
                    end
                    buf_d = DATA_W'(win >> (BYTE_BITS - used));
                    cnt_d = avail - used;
                end
            end
`ifdef EBPC_DEC_ZRLE_EN
            ZRUN: begin
                if (out_can) begin
                    emit  = 1'b1;
                    run_d = run_q - ZRL_W'(1);
                    if (run_q == ZRL_W'(1)) state_d = DECODE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Block end truncates any pending run and drops the rest of the ZNZ byte.
        if (emit) begin
            rem_d = rem_q - LOG_MAX_WORDS'(1);
            if (emit_last) begin
                state_d = IDLE;
                buf_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q <= 1'b0;
            buf_q  <= '0;
            cnt_q  <= '0;
            rem_q  <= '0;
`ifdef EBPC_DEC_ZRLE_EN
            run_q  <= '0;
`endif
            data_q <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            init_q <= 1'b1;
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
`ifdef EBPC_DEC_ZRLE_EN
            run_q  <= run_d;
`endif
            if (emit) begin
                data_q <= emit_data;
                last_q <= emit_last;
                vld_q  <= 1'b1;
            end else if (rdy_i) begin
                vld_q  <= 1'b0;
            end
        end
    end

    assign data_o = data_q;
    assign last_o = last_q;
    assign vld_o  = vld_q;

endmodule

// File: tb/tb_ebpc_decoder.sv
// Scoreboard bench for ebpc_decoder: directed vectors plus an encoder-driven random stream.
module tb_ebpc_decoder;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [23:0] num_words_i = '0;
    logic        num_words_vld_i = 1'b0;
    logic        num_words_rdy_o;
    logic [7:0]  bpc_i = '0;
    logic        bpc_vld_i = 1'b0;
    logic        bpc_rdy_o;
    logic [7:0]  znz_i = '0;
    logic        znz_vld_i = 1'b0;
    logic        znz_rdy_o;
    logic [7:0]  data_o;
    logic        last_o;
    logic        vld_o;
    logic        rdy_i = 1'b1;

    ebpc_decoder #(.DATA_W(8), .LOG_MAX_WORDS(24), .ZRL_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .num_words_i(num_words_i), .num_words_vld_i(num_words_vld_i), .num_words_rdy_o(num_words_rdy_o),
        .bpc_i(bpc_i), .bpc_vld_i(bpc_vld_i), .bpc_rdy_o(bpc_rdy_o),
        .znz_i(znz_i), .znz_vld_i(znz_vld_i), .znz_rdy_o(znz_rdy_o),
        .data_o(data_o), .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i)
    );

    always #5 clk = ~clk;

    logic [8:0]  exp_q[$];
    logic [23:0] nw_q[$];
    logic [7:0]  z_q[$];
    logic [7:0]  b_q[$];
    int          out_t[$];
    int checks = 0, errors = 0;
    int cyc = 0, n_out = 0, b_cnt = 0, nw_acc_cyc = 0;
    bit gaps = 0, rand_rdy = 0, bpc_rdy_seen = 0, abort = 0;
    logic [7:0] acc = '0;
    int         acc_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic blk(input int n);      nw_q.push_back(24'(n)); endtask
    task automatic zb(input logic [7:0] v); z_q.push_back(v); endtask
    task automatic bb(input logic [7:0] v); b_q.push_back(v); endtask
    task automatic ex(input logic [7:0] v, input logic l); exp_q.push_back({l, v}); endtask

    task automatic put_bit(input logic b);
        acc = {acc[6:0], b};
        acc_n++;
        if (acc_n == 8) begin
            z_q.push_back(acc);
            acc_n = 0;
        end
    endtask

    // Reference encoder: builds the ZNZ/BPC streams and the expected words for one block.
    task automatic gen_block(input int n);
        logic [7:0] w[$];
        int i, len;
        logic [3:0] r;
        for (int k = 0; k < n; k++) w.push_back(($urandom_range(0, 9) < 6) ? 8'h00 : 8'($urandom_range(1, 255)));
        blk(n);
        i = 0;
        while (i < n) begin
            if (w[i] != 8'h00) begin
                put_bit(1'b1);
                bb(w[i]);
                i++;
            end else begin
`ifdef EBPC_DEC_ZRLE_EN
                len = 0;
                while ((i + len < n) && (w[i+len] == 8'h00) && (len < 16)) len++;
                r = 4'(len - 1);
                if (i + len == n) r = 4'($urandom_range(len - 1, 15));
                put_bit(1'b0);
                for (int k = 3; k >= 0; k--) put_bit(r[k]);
                i += len;
`else
                len = 1;
                put_bit(1'b0);
                i += len;
`endif
            end
        end
        while (acc_n != 0) put_bit(1'($urandom_range(0, 1)));
        for (int k = 0; k < n; k++) ex(w[k], k == n - 1);
    endtask

    task automatic wait_done(input int limit, input string name);
        int c = 0;
        while ((exp_q.size() != 0 || nw_q.size() != 0 || z_q.size() != 0) && c < limit) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c >= limit) begin
            errors++;
            abort = 1;
            $display("FAIL %s_timeout: %0d words still expected after %0d cycles, required 0", name, exp_q.size(), c);
        end
        repeat (2) @(negedge clk);
    endtask

    // Stream drivers: handshakes sampled mid-cycle, inputs updated just after the edge.
    initial begin : drive
        bit nf, zf, bf;
        int ng, zg, bg;
        ng = 0; zg = 0; bg = 0;
        forever begin
            @(negedge clk);
            nf = num_words_vld_i && num_words_rdy_o;
            zf = znz_vld_i && znz_rdy_o;
            bf = bpc_vld_i && bpc_rdy_o;
            if (nf) nw_acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (!rst_ni) begin
                num_words_vld_i = 0; znz_vld_i = 0; bpc_vld_i = 0;
                ng = 0; zg = 0; bg = 0;
                rdy_i = 1'b1;
                continue;
            end
            if (nf) begin void'(nw_q.pop_front()); num_words_vld_i = 0; ng = gaps ? int'($urandom_range(0, 3)) : 0; end
            if (zf) begin void'(z_q.pop_front());  znz_vld_i = 0;       zg = gaps ? int'($urandom_range(0, 3)) : 0; end
            if (bf) begin void'(b_q.pop_front());  bpc_vld_i = 0;       bg = gaps ? int'($urandom_range(0, 3)) : 0; b_cnt++; end
            if (!num_words_vld_i) begin
                if (ng > 0) ng--;
                else if (nw_q.size() > 0) begin num_words_i = nw_q[0]; num_words_vld_i = 1; end
            end
            if (!znz_vld_i) begin
                if (zg > 0) zg--;
                else if (z_q.size() > 0) begin znz_i = z_q[0]; znz_vld_i = 1; end
            end
            if (!bpc_vld_i) begin
                if (bg > 0) bg--;
                else if (b_q.size() > 0) begin bpc_i = b_q[0]; bpc_vld_i = 1; end
            end
            rdy_i = rand_rdy ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
    end

    initial begin : monitor
        logic [8:0] e;
        logic       stall;
        logic [7:0] hd;
        logic       hl;
        stall = 0; hd = '0; hl = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                stall = 0;
                continue;
            end
            if (bpc_rdy_o) bpc_rdy_seen = 1;
            if (stall) begin
                checks++;
                if (!vld_o || data_o != hd || last_o != hl) begin
                    errors++;
                    $display("FAIL stall_hold: got vld=%0b data=%02h last=%0b, required vld=1 data=%02h last=%0b",
                             vld_o, data_o, last_o, hd, hl);
                end
            end
            if (vld_o && rdy_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra: got data=%02h last=%0b, required no beat", data_o, last_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({last_o, data_o} !== e) begin
                        errors++;
                        $display("FAIL out_word: got data=%02h last=%0b, required data=%02h last=%0b",
                                 data_o, last_o, e[7:0], e[8]);
                    end
                end
                out_t.push_back(cyc);
                n_out++;
            end
            stall = vld_o && !rdy_i;
            hd = data_o;
            hl = last_o;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vld"},    int'(vld_o), 0);
        chk({tag, "_data"},   int'(data_o), 0);
        chk({tag, "_last"},   int'(last_o), 0);
        chk({tag, "_nw_rdy"}, int'(num_words_rdy_o), 0);
        chk({tag, "_znz_rdy"}, int'(znz_rdy_o), 0);
        chk({tag, "_bpc_rdy"}, int'(bpc_rdy_o), 0);
    endtask

    initial begin : main
        int base, c, total;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        #2 rst_ni = 1'b1;
        @(negedge clk);
        chk("nw_rdy_after_reset", int'(num_words_rdy_o), 1);

        // Four non-zeros from one byte, back-to-back outputs.
        out_t.delete();
        base = b_cnt;
        blk(4); zb(8'hF0); bb(8'h11); bb(8'h22); bb(8'h33); bb(8'h44);
        ex(8'h11, 0); ex(8'h22, 0); ex(8'h33, 0); ex(8'h44, 1);
        wait_done(100, "t1");
        chk("t1_bpc_used", b_cnt - base, 4);
        if (out_t.size() == 4) begin
            chk("t1_consecutive", out_t[3] - out_t[0], 3);
            chk("t1_latency_ok", int'(out_t[0] - nw_acc_cyc <= 3), 1);
        end else chk("t1_out_count", out_t.size(), 4);

        // Zeros followed by one non-zero.
        if (!abort) begin
            base = b_cnt;
            blk(5);
`ifdef EBPC_DEC_ZRLE_EN
            zb(8'h1C);
`else
            zb(8'h08);
`endif
            bb(8'h7F);
            ex(8'h00, 0); ex(8'h00, 0); ex(8'h00, 0); ex(8'h00, 0); ex(8'h7F, 1);
            wait_done(100, "t2");
            chk("t2_bpc_used", b_cnt - base, 1);
        end

        // All-zero block with an idle BPC beat waiting that must not be taken.
        if (!abort) begin
            base = b_cnt;
            bpc_rdy_seen = 0;
            blk(20);
`ifdef EBPC_DEC_ZRLE_EN
            zb(8'h78); zb(8'hC0);
`else
            zb(8'h00); zb(8'h00); zb(8'h00);
`endif
            bb(8'h05);
            for (int k = 0; k < 20; k++) ex(8'h00, k == 19);
            wait_done(200, "t3");
            chk("t3_bpc_used", b_cnt - base, 0);
            chk("t3_bpc_rdy_seen", int'(bpc_rdy_seen), 0);
            chk("t3_bpc_left", b_q.size(), 1);
        end

        // Back-to-back single-word blocks; the left-over BPC beat is used here.
        if (!abort) begin
            base = b_cnt;
            blk(1); zb(8'h80);
            blk(1); zb(8'h00);
            ex(8'h05, 1); ex(8'h00, 1);
            wait_done(100, "t4");
            chk("t4_bpc_used", b_cnt - base, 1);
        end

        // Run longer than the block, then a block that must start byte-aligned.
        if (!abort) begin
            blk(3);
`ifdef EBPC_DEC_ZRLE_EN
            zb(8'h78);
`else
            zb(8'h00);
`endif
            blk(1); zb(8'h80); bb(8'h5A);
            ex(8'h00, 0); ex(8'h00, 0); ex(8'h00, 1); ex(8'h5A, 1);
            wait_done(100, "t5");
        end

        // Random blocks with gaps and output back-pressure.
        if (!abort) begin
            gaps = 1; rand_rdy = 1;
            total = 0;
            while (total < 5000) begin
                c = $urandom_range(1, 40);
                gen_block(c);
                total += c;
            end
            wait_done(80000, "rand");
            chk("rand_bpc_left", b_q.size(), 0);
            gaps = 0; rand_rdy = 0;
            repeat (3) @(negedge clk);
        end

        // Reset part-way through a block, then a fresh block.
        if (!abort) begin
            blk(8); zb(8'hFF);
            for (int k = 1; k <= 8; k++) begin bb(8'(k)); ex(8'(k), k == 8); end
            base = n_out; c = 0;
            while (n_out < base + 3 && c < 200) begin @(negedge clk); c++; end
            chk("t7_progress", int'(n_out >= base + 3), 1);
            #2 rst_ni = 1'b0;
            exp_q.delete(); nw_q.delete(); z_q.delete(); b_q.delete();
            #1 chk_reset_outputs("midreset");
            repeat (2) @(negedge clk);
            #2 rst_ni = 1'b1;
            base = b_cnt;
            blk(2); zb(8'h80); bb(8'h7F);
            ex(8'h7F, 0); ex(8'h00, 1);
            wait_done(100, "t7");
            chk("t7_bpc_used", b_cnt - base, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
